// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Contents:
//   state_t          - 4-bit FSM state encoding (debug-visible on state_o)
//   OP_* / FN_*      - supported opcodes and R-type funct codes
//   ALU_*            - alu_ctrl encodings
//   SRCB_*           - alu_src_b mux encodings
//   PCSRC_*          - pc_src mux encodings
//   is_zero_ext_op() - which immediate instructions zero-extend
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Logical immediates take the 16-bit field as unsigned.
    function automatic logic is_zero_ext_op(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU-operation decoder.
// Maps an opcode/funct pair to the ALU operation it needs and flags whether
// the pair is a supported instruction at all.
// Ports:
//   i_op       - opcode (instr[31:26])
//   i_fn       - funct (instr[5:0]), only meaningful for R-type
//   o_alu_ctrl - ALU operation for the execute step of this instruction
//   o_legal    - 1 when the opcode (and funct, for R-type) is supported
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_fn,
    output logic [2:0] o_alu_ctrl,
    output logic       o_legal
);

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        o_legal    = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                case (i_fn)
                    FN_ADD:  begin o_alu_ctrl = ALU_ADD; o_legal = 1'b1; end
                    FN_SUB:  begin o_alu_ctrl = ALU_SUB; o_legal = 1'b1; end
                    FN_AND:  begin o_alu_ctrl = ALU_AND; o_legal = 1'b1; end
                    FN_OR:   begin o_alu_ctrl = ALU_OR;  o_legal = 1'b1; end
                    FN_SLT:  begin o_alu_ctrl = ALU_SLT; o_legal = 1'b1; end
                    default: begin o_alu_ctrl = ALU_ADD; o_legal = 1'b0; end
                endcase
            end
            OP_LW, OP_SW, OP_ADDI, OP_J: begin
                o_alu_ctrl = ALU_ADD;
                o_legal    = 1'b1;
            end
            OP_BEQ: begin
                o_alu_ctrl = ALU_SUB;
                o_legal    = 1'b1;
            end
            OP_ANDI: begin
                o_alu_ctrl = ALU_AND;
                o_legal    = 1'b1;
            end
            OP_ORI: begin
                o_alu_ctrl = ALU_OR;
                o_legal    = 1'b1;
            end
            default: begin
                o_alu_ctrl = ALU_ADD;
                o_legal    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM.
// Sequences a shared PC / memory / register-file / ALU datapath: drives every
// mux select and write strobe, stalls on the memory ready handshake, flags
// unsupported instructions, and counts retired instructions.
// Ports:
//   clk, rst_n        - clock; asynchronous active-low reset
//   opcode, funct     - instruction fields, valid from the DECODE cycle on
//   zero              - ALU zero flag, used by beq
//   mem_ready         - memory access completes this cycle
//   pc_write, ir_write, mem_write, reg_write - write strobes
//   i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src,
//   ext_zero          - datapath selects
//   illegal_op        - one-cycle pulse in DECODE on an unsupported instruction
//   instr_count       - retired-instruction counter (wraps)
//   state_o           - current FSM state for debug
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 i_or_d,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [2:0]           alu_ctrl,
    output logic [1:0]           pc_src,
    output logic                 ext_zero,
    output logic                 illegal_op,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [3:0]           state_o
);

    state_t               r_state;
    state_t               w_state_next;
    logic [5:0]           r_op_q;
    logic [5:0]           r_fn_q;
    logic [CNT_WIDTH-1:0] r_instr_count;

    logic [5:0] w_dec_op;
    logic [5:0] w_dec_fn;
    logic [2:0] w_dec_alu;
    logic       w_dec_legal;
    logic       w_retire;

    // In DECODE the latched copies are not loaded yet, so the decoder looks at
    // the live instruction fields; every later state uses the latched copies.
    assign w_dec_op = (r_state == S_DECODE) ? opcode : r_op_q;
    assign w_dec_fn = (r_state == S_DECODE) ? funct  : r_fn_q;

    mips_alu_decoder u_alu_dec (
        .i_op       (w_dec_op),
        .i_fn       (w_dec_fn),
        .o_alu_ctrl (w_dec_alu),
        .o_legal    (w_dec_legal)
    );

    // An instruction retires on the edge that takes its last state back to
    // FETCH; an illegal DECODE->FETCH hop is deliberately not included.
    always_comb begin
        w_retire = 1'b0;
        if (w_state_next == S_FETCH) begin
            case (r_state)
                S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP: w_retire = 1'b1;
                default: w_retire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_op_q        <= 6'd0;
            r_fn_q        <= 6'd0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DECODE) begin
                r_op_q <= opcode;
                r_fn_q <= funct;
            end
            if (w_retire) begin
                r_instr_count <= r_instr_count + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        i_or_d       = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_RT;
        alu_ctrl     = ALU_AND;
        pc_src       = PCSRC_ALU;
        ext_zero     = 1'b0;
        illegal_op   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_FETCH;
            end
            S_FETCH: begin
                // PC+4 is computed every FETCH cycle but only committed,
                // together with the IR, when the memory delivers.
                i_or_d    = 1'b0;
                alu_src_a = 1'b0;
                alu_src_b = SRCB_FOUR;
                alu_ctrl  = ALU_ADD;
                pc_src    = PCSRC_ALU;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                w_state_next = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target precompute: PC + (sext(imm) << 2).
                alu_src_a = 1'b0;
                alu_src_b = SRCB_IMM_SH;
                alu_ctrl  = ALU_ADD;
                ext_zero  = 1'b0;
                if (!w_dec_legal) begin
                    illegal_op   = 1'b1;
                    w_state_next = S_FETCH;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW:             w_state_next = S_MEMADR;
                        OP_RTYPE:                 w_state_next = S_EXEC;
                        OP_BEQ:                   w_state_next = S_BRANCH;
                        OP_ADDI, OP_ANDI, OP_ORI: w_state_next = S_IMMEX;
                        OP_J:                     w_state_next = S_JUMP;
                        default:                  w_state_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = ALU_ADD;
                ext_zero  = 1'b0;
                w_state_next = (r_op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                i_or_d = 1'b1;
                w_state_next = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                reg_dst    = 1'b0;
                w_state_next = S_FETCH;
            end
            S_MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                w_state_next = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RT;
                alu_ctrl  = w_dec_alu;
                w_state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                mem_to_reg = 1'b0;
                w_state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RT;
                alu_ctrl  = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_write  = zero;
                w_state_next = S_FETCH;
            end
            S_IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = w_dec_alu;
                ext_zero  = is_zero_ext_op(r_op_q);
                w_state_next = S_IMMWB;
            end
            S_IMMWB: begin
                // Extender select stays put so the written value is stable.
                reg_write  = 1'b1;
                reg_dst    = 1'b0;
                mem_to_reg = 1'b0;
                ext_zero   = is_zero_ext_op(r_op_q);
                w_state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
                w_state_next = S_FETCH;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign instr_count = r_instr_count;
    assign state_o     = r_state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl. The driver plays whole instructions one
// clock slot at a time; for each slot it pushes the control word the
// instruction should produce at that point, and a monitor on the falling edge
// pops and compares against what the DUT presents.
module tb_mips_mc_ctrl;

    // State numbering as listed for the debug output, in order.
    localparam logic [3:0] T_IDLE = 4'd0, T_FETCH = 4'd1, T_DECODE = 4'd2,
                           T_MEMADR = 4'd3, T_MEMRD = 4'd4, T_MEMWB = 4'd5,
                           T_MEMWR = 4'd6, T_EXEC = 4'd7, T_ALUWB = 4'd8,
                           T_BRANCH = 4'd9, T_IMMEX = 4'd10, T_IMMWB = 4'd11,
                           T_JUMP = 4'd12;

    localparam logic [5:0] C_R = 6'h00, C_J = 6'h02, C_BEQ = 6'h04, C_ADDI = 6'h08,
                           C_ANDI = 6'h0C, C_ORI = 6'h0D, C_LW = 6'h23, C_SW = 6'h2B;

    localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010,
                           A_SUB = 3'b110, A_SLT = 3'b111;

    typedef struct packed {
        logic [3:0]  st;
        logic        pc_write;
        logic        ir_write;
        logic        mem_write;
        logic        reg_write;
        logic        i_or_d;
        logic        reg_dst;
        logic        mem_to_reg;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        logic [2:0]  alu_ctrl;
        logic [1:0]  pc_src;
        logic        ext_zero;
        logic        illegal_op;
        logic [31:0] cnt;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, ir_write, mem_write, reg_write, i_or_d, reg_dst;
    logic        mem_to_reg, alu_src_a, ext_zero, illegal_op;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_ctrl;
    logic [31:0] instr_count;
    logic [3:0]  state_o;

    rec_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          slot_no = 0;
    logic [31:0] model_cnt = 32'd0;

    mips_mc_ctrl #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .mem_write(mem_write), .reg_write(reg_write), .i_or_d(i_or_d),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
        .ext_zero(ext_zero), .illegal_op(illegal_op), .instr_count(instr_count),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        rec_t act;
        rec_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act.st = state_o;         act.pc_write = pc_write;   act.ir_write = ir_write;
            act.mem_write = mem_write; act.reg_write = reg_write; act.i_or_d = i_or_d;
            act.reg_dst = reg_dst;    act.mem_to_reg = mem_to_reg; act.alu_src_a = alu_src_a;
            act.alu_src_b = alu_src_b; act.alu_ctrl = alu_ctrl;  act.pc_src = pc_src;
            act.ext_zero = ext_zero;  act.illegal_op = illegal_op; act.cnt = instr_count;
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL ctrl slot %0d: state got %0d want %0d, word got %h want %h, count got %0d want %0d",
                         slot_no, act.st, e.st, act[52:32], e[52:32], act.cnt, e.cnt);
            end
            slot_no++;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [5:0] r6();
        return 6'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic rec_t base(input logic [3:0] st);
        rec_t e;
        e = '0;
        e.st  = st;
        e.cnt = model_cnt;
        return e;
    endfunction

    function automatic bit fn_ok(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    endfunction

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == C_R) return fn_ok(fn);
        return op inside {C_J, C_BEQ, C_ADDI, C_ANDI, C_ORI, C_LW, C_SW};
    endfunction

    function automatic logic [2:0] rfn_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return A_ADD;
            6'h22:   return A_SUB;
            6'h24:   return A_AND;
            6'h25:   return A_OR;
            default: return A_SLT;
        endcase
    endfunction

    // One clock slot: drive inputs just after the rising edge, queue the
    // control word expected during this slot, advance to the next edge.
    task automatic slot(input logic rn, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic mr, input rec_t e);
        rst_n = rn; opcode = op; funct = fn; zero = z; mem_ready = mr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Slot where the only meaningful input is reset; the rest is noise.
    task automatic rslot(input rec_t e);
        slot(1'b1, r6(), r6(), rb(), rb(), e);
    endtask

    task automatic do_reset();
        model_cnt = 32'd0;
        slot(1'b0, r6(), r6(), rb(), rb(), base(T_IDLE));
        slot(1'b0, r6(), r6(), rb(), rb(), base(T_IDLE));
        slot(1'b1, r6(), r6(), rb(), rb(), base(T_IDLE));
    endtask

    // One instruction from FETCH back to FETCH. fw/mw are memory wait cycles
    // in FETCH and in the data access; rst_at >= 0 drops reset at that data
    // access cycle instead of finishing.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw, input int rst_at);
        rec_t e;
        bit   legal;
        for (int i = 0; i <= fw; i++) begin
            e = base(T_FETCH);
            e.alu_src_b = 2'b01;
            e.alu_ctrl  = A_ADD;
            e.ir_write  = (i == fw);
            e.pc_write  = (i == fw);
            slot(1'b1, r6(), r6(), rb(), (i == fw), e);
        end
        legal = is_legal(op, fn);
        e = base(T_DECODE);
        e.alu_src_b  = 2'b11;
        e.alu_ctrl   = A_ADD;
        e.illegal_op = !legal;
        slot(1'b1, op, fn, rb(), rb(), e);
        if (!legal) return;
        case (op)
            C_LW, C_SW: begin
                e = base(T_MEMADR);
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctrl = A_ADD;
                rslot(e);
                for (int i = 0; i <= mw; i++) begin
                    if (i == rst_at) begin
                        do_reset();
                        return;
                    end
                    e = base(op == C_LW ? T_MEMRD : T_MEMWR);
                    e.i_or_d    = 1'b1;
                    e.mem_write = (op == C_SW);
                    slot(1'b1, r6(), r6(), rb(), (i == mw), e);
                end
                if (op == C_LW) begin
                    e = base(T_MEMWB);
                    e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                    rslot(e);
                end
            end
            C_R: begin
                e = base(T_EXEC);
                e.alu_src_a = 1'b1; e.alu_ctrl = rfn_alu(fn);
                rslot(e);
                e = base(T_ALUWB);
                e.reg_write = 1'b1; e.reg_dst = 1'b1;
                rslot(e);
            end
            C_BEQ: begin
                e = base(T_BRANCH);
                e.alu_src_a = 1'b1; e.alu_ctrl = A_SUB; e.pc_src = 2'b01; e.pc_write = z;
                slot(1'b1, r6(), r6(), z, rb(), e);
            end
            C_ADDI, C_ANDI, C_ORI: begin
                e = base(T_IMMEX);
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                e.alu_ctrl  = (op == C_ADDI) ? A_ADD : (op == C_ANDI) ? A_AND : A_OR;
                e.ext_zero  = (op != C_ADDI);
                rslot(e);
                e = base(T_IMMWB);
                e.reg_write = 1'b1;
                e.ext_zero  = (op != C_ADDI);
                rslot(e);
            end
            default: begin
                e = base(T_JUMP);
                e.pc_src = 2'b10; e.pc_write = 1'b1;
                rslot(e);
            end
        endcase
        model_cnt = model_cnt + 32'd1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] ops[8];
        logic [5:0] fns[5];
        logic [5:0] op;
        logic [5:0] fn;
        ops = '{C_LW, C_SW, C_R, C_BEQ, C_ADDI, C_ANDI, C_ORI, C_J};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        @(posedge clk);
        #1;
        do_reset();

        run_instr(C_LW,   6'h00, 1'b0, 0, 0, -1);
        run_instr(C_ORI,  6'h00, 1'b0, 0, 0, -1);
        run_instr(C_ADDI, 6'h00, 1'b0, 0, 0, -1);
        run_instr(C_BEQ,  6'h00, 1'b1, 0, 0, -1);
        run_instr(C_BEQ,  6'h00, 1'b0, 0, 0, -1);
        run_instr(C_SW,   6'h00, 1'b0, 0, 3, -1);
        run_instr(C_R,    6'h22, 1'b0, 2, 0, -1);
        run_instr(6'h3F,  6'h00, 1'b0, 0, 0, -1);
        run_instr(C_R,    6'h03, 1'b0, 0, 0, -1);
        run_instr(C_J,    6'h00, 1'b0, 0, 0, -1);
        run_instr(C_LW,   6'h00, 1'b0, 0, 5, 2);
        run_instr(C_ANDI, 6'h00, 1'b0, 1, 0, -1);

        for (int n = 0; n < 300; n++) begin
            int k;
            k  = int'($urandom_range(0, 9));
            fn = fns[$urandom_range(0, 4)];
            if (k < 8) begin
                op = ops[k];
            end else if (k == 8) begin
                op = r6();
                if (is_legal(op, fn)) op = 6'h3F;
            end else begin
                op = C_R;
                fn = r6();
                if (fn_ok(fn)) fn = 6'h03;
            end
            run_instr(op, fn, rb(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 19) == 0) ? 1 : -1);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending entries got %0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
